snd_bus_seq: RTL and testbench

//  Sequences the shared sound-chip aux bus (aa0/ad/n_ard/n_awr plus chip selects) used by YM1, YM2 and SAA1099.

---
 rtl/snd_bus_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_snd_bus_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_bus_seq.sv
// Aux sound bus sequencer for YM1, YM2 and SAA1099.
// Decoded CPU port accesses arrive over a valid/ready handshake. Each one is
// replayed on the shared aux bus as a setup -> strobe -> hold cycle, timed in
// clk32 ticks. Writes can be posted into a one-deep pending slot. Reads hold
// the Z80 in wait until the chip data has been captured.
// Every chip-facing pin is driven straight from a flop, so the pins cannot
// glitch.
module snd_bus_seq #(
  parameter int T_SETUP    = 2,
  parameter int T_STROBE   = 8,
  parameter int T_STROBE_S = 10,
  parameter int T_HOLD     = 2
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [1:0] req_sel,
  input  logic       req_a0,
  input  logic [7:0] req_d,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       wait_n,
  output logic       aa0,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       n_ard,
  output logic       n_awr,
  output logic       n_ym1_cs,
  output logic       n_ym2_cs,
  output logic       n_saa_cs
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] LD_SETUP    = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_STROBE   = 4'(T_STROBE - 1);
  localparam logic [3:0] LD_STROBE_S = 4'(T_STROBE_S - 1);
  localparam logic [3:0] LD_HOLD     = 4'(T_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Fields of the bus cycle currently on the pins.
  logic       cur_rd, cur_rd_nxt;
  logic [1:0] cur_sel, cur_sel_nxt;
  logic       cur_a0, cur_a0_nxt;
  logic [7:0] cur_d, cur_d_nxt;

  // One-deep posted write slot.
  logic       slot_full, slot_full_nxt;
  logic [1:0] slot_sel, slot_sel_nxt;
  logic       slot_a0, slot_a0_nxt;
  logic [7:0] slot_d, slot_d_nxt;

  logic       rd_wait, rd_wait_nxt;
  logic [7:0] rd_data_nxt;
  logic       rd_valid_nxt;

  logic [2:0] cs_n_nxt;
  logic       ad_oe_nxt, n_ard_nxt, n_awr_nxt;

  logic       accept, drop, take, load_slot, load_req;

  // Reads need an idle bus and an empty slot. Writes only need a free slot.
  assign req_ready = req_rd ? ((state == IDLE) && !slot_full) : !slot_full;
  assign busy      = (state != IDLE) || slot_full;
  assign accept    = req_valid && req_ready;
  assign drop      = (req_sel == 2'd3) || ((req_sel == 2'd2) && req_rd);
  assign take      = accept && !drop;
  assign wait_n    = !((req_valid && !req_ready) || rd_wait || (accept && req_rd));
  assign aa0       = cur_a0;
  assign ad_out    = cur_d;

  // Phase sequencing, slot management, read capture and the next pin values.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cur_rd_nxt    = cur_rd;
    cur_sel_nxt   = cur_sel;
    cur_a0_nxt    = cur_a0;
    cur_d_nxt     = cur_d;
    slot_full_nxt = slot_full;
    slot_sel_nxt  = slot_sel;
    slot_a0_nxt   = slot_a0;
    slot_d_nxt    = slot_d;
    rd_wait_nxt   = rd_wait;
    rd_data_nxt   = rd_data;
    rd_valid_nxt  = 1'b0;
    load_slot     = 1'b0;
    load_req      = 1'b0;
    cs_n_nxt      = 3'b111;

    case (state)
      IDLE: begin
        if (slot_full) load_slot = 1'b1;
        else if (take) load_req = 1'b1;
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = (cur_sel == 2'd2) ? LD_STROBE_S : LD_STROBE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = LD_HOLD;
          if (cur_rd) begin
            rd_data_nxt  = ad_in;
            rd_valid_nxt = 1'b1;
            rd_wait_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          if (slot_full) load_slot = 1'b1;
          else if (take) load_req = 1'b1;
          else state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load_slot) begin
      state_nxt     = SETUP;
      cnt_nxt       = LD_SETUP;
      cur_rd_nxt    = 1'b0;
      cur_sel_nxt   = slot_sel;
      cur_a0_nxt    = slot_a0;
      cur_d_nxt     = slot_d;
      slot_full_nxt = 1'b0;
    end

    if (load_req) begin
      state_nxt   = SETUP;
      cnt_nxt     = LD_SETUP;
      cur_rd_nxt  = req_rd;
      cur_sel_nxt = req_sel;
      cur_a0_nxt  = req_a0;
      cur_d_nxt   = req_d;
      if (req_rd) rd_wait_nxt = 1'b1;
    end else if (take && !req_rd) begin
      slot_full_nxt = 1'b1;
      slot_sel_nxt  = req_sel;
      slot_a0_nxt   = req_a0;
      slot_d_nxt    = req_d;
    end

    if (accept && drop && req_rd) begin
      rd_data_nxt  = 8'hFF;
      rd_valid_nxt = 1'b1;
    end

    if (state_nxt != IDLE) begin
      case (cur_sel_nxt)
        2'd0:    cs_n_nxt = 3'b110;
        2'd1:    cs_n_nxt = 3'b101;
        2'd2:    cs_n_nxt = 3'b011;
        default: cs_n_nxt = 3'b111;
      endcase
    end
    ad_oe_nxt = (state_nxt != IDLE) && !cur_rd_nxt;
    n_awr_nxt = !((state_nxt == STROBE) && !cur_rd_nxt);
    n_ard_nxt = !((state_nxt == STROBE) && cur_rd_nxt);
  end

  // State, cycle fields, slot and the registered chip pins.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cur_rd    <= 1'b0;
      cur_sel   <= 2'd0;
      cur_a0    <= 1'b0;
      cur_d     <= 8'd0;
      slot_full <= 1'b0;
      slot_sel  <= 2'd0;
      slot_a0   <= 1'b0;
      slot_d    <= 8'd0;
      rd_wait   <= 1'b0;
      rd_data   <= 8'd0;
      rd_valid  <= 1'b0;
      n_ym1_cs  <= 1'b1;
      n_ym2_cs  <= 1'b1;
      n_saa_cs  <= 1'b1;
      ad_oe     <= 1'b0;
      n_ard     <= 1'b1;
      n_awr     <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur_rd    <= cur_rd_nxt;
      cur_sel   <= cur_sel_nxt;
      cur_a0    <= cur_a0_nxt;
      cur_d     <= cur_d_nxt;
      slot_full <= slot_full_nxt;
      slot_sel  <= slot_sel_nxt;
      slot_a0   <= slot_a0_nxt;
      slot_d    <= slot_d_nxt;
      rd_wait   <= rd_wait_nxt;
      rd_data   <= rd_data_nxt;
      rd_valid  <= rd_valid_nxt;
      n_ym1_cs  <= cs_n_nxt[0];
      n_ym2_cs  <= cs_n_nxt[1];
      n_saa_cs  <= cs_n_nxt[2];
      ad_oe     <= ad_oe_nxt;
      n_ard     <= n_ard_nxt;
      n_awr     <= n_awr_nxt;
    end
  end

endmodule

// File: tb/tb_snd_bus_seq.sv
// Testbench for snd_bus_seq.
// The driver issues requests and, when one is accepted, pushes the expected bus
// cycle and read response into queues. A monitor process observes the pins and
// compares each completed strobe and each rd_valid pulse against those queues.
// The reference model is a timeline: a cycle starts at max(accept+1, bus_end).
module tb_snd_bus_seq;
  localparam int T_SETUP    = 2;
  localparam int T_STROBE   = 8;
  localparam int T_STROBE_S = 10;
  localparam int T_HOLD     = 2;

  logic       clk32 = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rd = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic       req_a0 = 1'b0;
  logic [7:0] req_d = 8'd0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, wait_n, aa0, ad_oe, n_ard, n_awr;
  logic       n_ym1_cs, n_ym2_cs, n_saa_cs;
  logic [7:0] ad_out;
  logic [7:0] ad_in = 8'd0;

  snd_bus_seq #(
    .T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_STROBE_S(T_STROBE_S), .T_HOLD(T_HOLD)
  ) dut (
    .clk32(clk32), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_sel(req_sel), .req_a0(req_a0), .req_d(req_d),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .wait_n(wait_n),
    .aa0(aa0), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .n_ard(n_ard), .n_awr(n_awr), .n_ym1_cs(n_ym1_cs), .n_ym2_cs(n_ym2_cs),
    .n_saa_cs(n_saa_cs)
  );

  always #5 clk32 = ~clk32;

  int cyc = 0;
  always @(posedge clk32) cyc <= cyc + 1;

  typedef struct {
    int         sel;
    bit         rd;
    bit         a0;
    logic [7:0] d;
    int         st;
    int         len;
  } bus_t;

  typedef struct {
    logic [7:0] d;
    int         at;
  } rdx_t;

  bus_t exp_bus[$];
  rdx_t exp_rd[$];
  int   bus_end = 0;
  int   last_start = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request, hold it until it is accepted, and record the expectations.
  task automatic applyStimulus(input bit rd, input int sel, input bit a0, input logic [7:0] d,
                               input logic [7:0] adv, output int acc);
    bit         dropped, done;
    int         start, len;
    logic [7:0] rdv;
    dropped = (sel == 3) || (sel == 2 && rd);
    rdv = 8'hFF;
    req_rd = rd;
    req_sel = 2'(sel);
    req_a0 = a0;
    req_d = d;
    if (rd && !dropped) begin
      rdv = adv;
      ad_in = adv;
    end
    req_valid = 1'b1;
    done = 1'b0;
    acc = -1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk32);
      checkOutput("req_ready", req_ready, rd ? (cyc >= bus_end) : (cyc >= last_start));
      if (!req_ready) begin
        checkOutput("wait_stall", wait_n, 0);
        @(posedge clk32);
        #1;
      end else begin
        done = 1'b1;
        acc = cyc;
        if (!dropped) begin
          start = (cyc + 1 > bus_end) ? cyc + 1 : bus_end;
          len = (sel == 2) ? T_STROBE_S : T_STROBE;
          bus_end = start + T_SETUP + len + T_HOLD;
          last_start = start;
          exp_bus.push_back('{sel, rd, a0, d, start + T_SETUP, len});
          if (rd) exp_rd.push_back('{rdv, start + T_SETUP + len});
        end else if (rd) begin
          exp_rd.push_back('{rdv, cyc + 1});
        end
      end
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    if (done && rd) checkOutput("wait_accept", wait_n, 0);
    @(posedge clk32);
    #1;
    req_valid = 1'b0;
    if (done && rd) begin
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
        @(negedge clk32);
        if (rd_valid) begin
          checkOutput("wait_release", wait_n, 1);
          done = 1'b1;
        end else begin
          checkOutput("wait_read", wait_n, 0);
        end
      end
      if (!done) checkOutput("rd_valid_timeout", 0, 1);
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge clk32);
      idle = (exp_bus.size() == 0) && (exp_rd.size() == 0) && !busy;
    end
    if (!idle) checkOutput("idle_timeout", 0, 1);
    @(posedge clk32);
    #1;
  endtask

  // Monitor: rebuild each strobe from the pins and score it against the queues.
  bit   in_strb = 1'b0;
  bit   obs_bad;
  bus_t obs;
  bus_t e;
  rdx_t r;
  int   ncs;
  int   osel;
  always @(negedge clk32) begin
    if (!rst_n) begin
      in_strb = 1'b0;
    end else begin
      ncs = int'(!n_ym1_cs) + int'(!n_ym2_cs) + int'(!n_saa_cs);
      checkOutput("cs_onehot", ncs <= 1, 1);
      osel = !n_ym1_cs ? 0 : (!n_ym2_cs ? 1 : (!n_saa_cs ? 2 : 3));
      if ((!n_awr || !n_ard) && !in_strb) begin
        in_strb = 1'b1;
        obs = '{osel, !n_ard, aa0, ad_out, cyc, 1};
        obs_bad = (!n_awr && !n_ard) || (ad_oe != n_ard);
      end else if ((!n_awr || !n_ard) && in_strb) begin
        obs.len++;
        if (osel != obs.sel || aa0 != obs.a0 || (!obs.rd && ad_out != obs.d) ||
            ad_oe != !obs.rd || (!n_awr && !n_ard) || !n_ard != obs.rd)
          obs_bad = 1'b1;
      end else if (in_strb) begin
        in_strb = 1'b0;
        if (exp_bus.size() == 0) begin
          checkOutput("bus_unexpected", 1, 0);
        end else begin
          e = exp_bus.pop_front();
          checkOutput("bus_start", obs.st, e.st);
          checkOutput("bus_len", obs.len, e.len);
          checkOutput("bus_sel", obs.sel, e.sel);
          checkOutput("bus_rd", obs.rd, e.rd);
          checkOutput("bus_a0", obs.a0, e.a0);
          if (!e.rd) checkOutput("bus_data", obs.d, e.d);
          checkOutput("bus_stable", obs_bad, 0);
          checkOutput("hold_cs", osel, e.sel);
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          checkOutput("rd_unexpected", 1, 0);
        end else begin
          r = exp_rd.pop_front();
          checkOutput("rd_data", rd_data, r.d);
          checkOutput("rd_cycle", cyc, r.at);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         a, a1, a2, a3, ar;
    logic [7:0] tr_cs[14];
    logic [7:0] tr_awr[14];
    int         data_bad;
    bit         seen;

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk32);
    #1;
    checkOutput("rst_n_ard", n_ard, 1);
    checkOutput("rst_n_awr", n_awr, 1);
    checkOutput("rst_ym1_cs", n_ym1_cs, 1);
    checkOutput("rst_ym2_cs", n_ym2_cs, 1);
    checkOutput("rst_saa_cs", n_saa_cs, 1);
    checkOutput("rst_ad_oe", ad_oe, 0);
    checkOutput("rst_wait_n", wait_n, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(posedge clk32);
    #1;

    // Isolated YM1 write: trace CS and strobe for 14 cycles after accept.
    applyStimulus(0, 0, 1, 8'hA5, 8'h00, a);
    data_bad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk32);
      tr_cs[i] = {7'd0, n_ym1_cs};
      tr_awr[i] = {7'd0, n_awr};
      if (!n_ym1_cs && (ad_out != 8'hA5 || !ad_oe || !aa0 || !n_ard)) data_bad++;
    end
    for (int i = 0; i < 14; i++) begin
      checkOutput("trace_cs", tr_cs[i], (i < 12) ? 0 : 1);
      checkOutput("trace_awr", tr_awr[i], (i >= 2 && i <= 9) ? 0 : 1);
    end
    checkOutput("trace_data", data_bad, 0);
    @(posedge clk32);
    #1;

    // Asynchronous reset in the middle of a write strobe.
    applyStimulus(0, 0, 0, 8'h5A, 8'h00, a);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk32);
      seen = !n_awr;
    end
    checkOutput("reach_strobe", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_n_awr", n_awr, 1);
    checkOutput("arst_ym1_cs", n_ym1_cs, 1);
    checkOutput("arst_ad_oe", ad_oe, 0);
    checkOutput("arst_busy", busy, 0);
    exp_bus.delete();
    exp_rd.delete();
    bus_end = 0;
    last_start = 0;
    @(negedge clk32);
    #1;
    rst_n = 1'b1;
    @(posedge clk32);
    #1;

    // Read YM2 with a known bus value.
    applyStimulus(1, 1, 0, 8'h00, 8'h3C, a);
    waitIdle();

    // Three writes back to back: second is posted, third waits for the pop.
    applyStimulus(0, 0, 0, 8'h11, 8'h00, a1);
    applyStimulus(0, 1, 1, 8'h22, 8'h00, a2);
    applyStimulus(0, 0, 1, 8'h33, 8'h00, a3);
    checkOutput("b2b_second_accept", a2, a1 + 1);
    checkOutput("b2b_third_accept", a3, a1 + 1 + 12);
    waitIdle();

    // SAA write, SAA read, and both kinds of reserved access.
    applyStimulus(0, 2, 1, 8'h1C, 8'h00, a);
    waitIdle();
    applyStimulus(1, 2, 0, 8'h00, 8'h00, a);
    applyStimulus(1, 3, 1, 8'h00, 8'h00, a);
    applyStimulus(0, 3, 0, 8'h77, 8'h00, a);
    waitIdle();

    // Read issued behind a running write and a posted write.
    applyStimulus(0, 0, 1, 8'h44, 8'h00, a1);
    applyStimulus(0, 2, 0, 8'h55, 8'h00, a2);
    applyStimulus(1, 0, 1, 8'h00, 8'hC3, ar);
    checkOutput("read_after_pending", ar, a1 + 1 + 12 + 14);
    waitIdle();

    // Randomized traffic.
    for (int k = 0; k < 80; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk32);
        #1;
      end
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3), 1'($urandom),
                    8'($urandom), 8'($urandom), a);
    end
    waitIdle();
    checkOutput("bus_queue_empty", exp_bus.size(), 0);
    checkOutput("rd_queue_empty", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
